// File: rtl/flex_uart_pkg.sv
// Shared types for the flexible UART receiver: parity selection and receiver FSM states.
package flex_uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_mode_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } rx_state_e;

    // Code 2'b11 has no meaning of its own and behaves like "no parity".
    function automatic parity_mode_e decode_parity(input logic [1:0] mode);
        case (mode)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-stage flop synchronizer for asynchronous level inputs, with a selectable reset value.
module bit_synchronizer #(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_reg [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_reg[i] <= RESET_VAL;
            end
        end else begin
            sync_reg[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/rx_fifo.sv
// Show-ahead receive FIFO; the head entry is presented whenever the FIFO is non-empty.
module rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_wr;
    logic             do_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_flex.sv
// Oversampling UART receiver with runtime parity / stop-bit selection, error flags and a receive FIFO.
module uart_rx_flex
    import flex_uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_in,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    input  logic                          rd_en,
    input  logic                          clear_errors,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    output logic                          rx_perr,
    output logic                          rx_ferr,
    output logic                          framing_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int              TW        = $clog2(OVERSAMPLE);
    localparam int              BW        = $clog2(DATA_BITS);
    localparam logic [TW-1:0]   TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0]   TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0]   BIT_LAST  = BW'(DATA_BITS - 1);

    logic                   rx_sync;
    rx_state_e              state_reg;
    logic [TW-1:0]          tick_reg;
    logic [BW-1:0]          bit_cnt_reg;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   par_acc_reg;
    logic                   perr_reg;
    logic                   ferr_reg;
    parity_mode_e           par_mode_reg;
    logic                   two_stop_reg;
    logic                   framing_err_reg;
    logic                   parity_err_reg;
    logic                   overrun_reg;

    logic                   sample;
    logic                   frame_done;
    logic                   frame_ferr;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_BITS+1:0]   fifo_rd_data;

    bit_synchronizer #(
        .WIDTH     (1),
        .STAGES    (2),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_in),
        .q     (rx_sync)
    );

    // The tick counter restarts on the start edge, so mid-bit lands on TICK_MID in every bit.
    assign sample     = (state_reg != IDLE) && (tick_reg == TICK_MID);
    assign frame_done = sample && ((state_reg == STOP1 && !two_stop_reg) || state_reg == STOP2);
    assign frame_ferr = ferr_reg | ~rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            tick_reg     <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            par_acc_reg  <= 1'b0;
            perr_reg     <= 1'b0;
            ferr_reg     <= 1'b0;
            par_mode_reg <= PAR_NONE;
            two_stop_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE) tick_reg <= '0;
            else                   tick_reg <= (tick_reg == TICK_LAST) ? '0 : tick_reg + 1'b1;

            case (state_reg)
                IDLE: begin
                    if (!rx_sync) state_reg <= START;
                end
                START: begin
                    if (sample) begin
                        if (rx_sync) begin
                            state_reg <= IDLE;
                        end else begin
                            state_reg    <= DATA;
                            par_mode_reg <= decode_parity(parity_mode);
                            two_stop_reg <= two_stop;
                            bit_cnt_reg  <= '0;
                            par_acc_reg  <= 1'b0;
                            perr_reg     <= 1'b0;
                            ferr_reg     <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (sample) begin
                        shift_reg   <= {rx_sync, shift_reg[DATA_BITS-1:1]};
                        par_acc_reg <= par_acc_reg ^ rx_sync;
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == BIT_LAST)
                            state_reg <= (par_mode_reg == PAR_NONE) ? STOP1 : PARITY;
                    end
                end
                PARITY: begin
                    if (sample) begin
                        perr_reg  <= (par_mode_reg == PAR_EVEN) ? (par_acc_reg ^ rx_sync)
                                                                : ~(par_acc_reg ^ rx_sync);
                        state_reg <= STOP1;
                    end
                end
                STOP1: begin
                    if (sample) begin
                        if (!rx_sync) ferr_reg <= 1'b1;
                        state_reg <= two_stop_reg ? STOP2 : IDLE;
                    end
                end
                STOP2: begin
                    if (sample) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Sticky flags: a new error on the write cycle wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            framing_err_reg <= 1'b0;
            parity_err_reg  <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            if (frame_done && frame_ferr)  framing_err_reg <= 1'b1;
            else if (clear_errors)         framing_err_reg <= 1'b0;
            if (frame_done && perr_reg)    parity_err_reg  <= 1'b1;
            else if (clear_errors)         parity_err_reg  <= 1'b0;
            if (frame_done && fifo_full && !rd_en) overrun_reg <= 1'b1;
            else if (clear_errors)                 overrun_reg <= 1'b0;
        end
    end

    rx_fifo #(
        .WIDTH (DATA_BITS + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (frame_done),
        .wr_data ({perr_reg, frame_ferr, shift_reg}),
        .rd_en   (rd_en),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign rx_data     = fifo_rd_data[DATA_BITS-1:0];
    assign rx_ferr     = fifo_rd_data[DATA_BITS];
    assign rx_perr     = fifo_rd_data[DATA_BITS+1];
    assign rx_valid    = !fifo_empty;
    assign framing_err = framing_err_reg;
    assign parity_err  = parity_err_reg;
    assign overrun     = overrun_reg;

endmodule

// File: tb/tb_uart_rx_flex.sv
// Self-checking bench for uart_rx_flex: table of frame formats plus hand-written corner sequences.
module tb_uart_rx_flex;

    localparam int DB    = 8;
    localparam int OS    = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic [1:0] parity_mode = 2'b00;
    logic       two_stop = 1'b0;
    logic       rd_en = 1'b0;
    logic       clear_errors = 1'b0;
    logic [DB-1:0] rx_data;
    logic       rx_valid, rx_perr, rx_ferr;
    logic       framing_err, parity_err, overrun;
    logic [$clog2(DEPTH):0] fifo_count;

    uart_rx_flex #(
        .DATA_BITS  (DB),
        .OVERSAMPLE (OS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_in        (rx_in),
        .parity_mode  (parity_mode),
        .two_stop     (two_stop),
        .rd_en        (rd_en),
        .clear_errors (clear_errors),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_perr      (rx_perr),
        .rx_ferr      (rx_ferr),
        .framing_err  (framing_err),
        .parity_err   (parity_err),
        .overrun      (overrun),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] pmode;
        logic       two_sb;
        logic       par_flip;
        logic       stop1_low;
        logic       stop2_low;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[9];
    int   checks = 0;
    int   errors = 0;
    int   frame_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic p, input logic f);
        exp_t e;
        e.data = d;
        e.perr = p;
        e.ferr = f;
        sb_q.push_back(e);
    endtask

    // Drives one whole frame, then leaves the line idle for one bit period.
    task automatic send_frame(input logic [7:0] data, input logic [1:0] pmode, input logic two_sb,
                              input logic par_flip, input logic stop1_low, input logic stop2_low);
        @(negedge clk);
        rx_in = 1'b0;
        repeat (OS) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rx_in = data[i];
            repeat (OS) @(negedge clk);
        end
        if (pmode == 2'b01 || pmode == 2'b10) begin
            rx_in = (^data) ^ (pmode == 2'b10) ^ par_flip;
            repeat (OS) @(negedge clk);
        end
        rx_in = ~stop1_low;
        repeat (OS) @(negedge clk);
        if (two_sb) begin
            rx_in = ~stop2_low;
            repeat (OS) @(negedge clk);
        end
        rx_in = 1'b1;
        repeat (OS) @(negedge clk);
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        int   w = 0;
        while (!rx_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({name, " rx_valid"}, rx_valid, 1);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got entry %02h, expected no entry", name, rx_data);
        end else begin
            e = sb_q.pop_front();
            check({name, " rx_data"}, rx_data, e.data);
            check({name, " rx_perr"}, rx_perr, e.perr);
            check({name, " rx_ferr"}, rx_ferr, e.ferr);
            $display("frame %0d %s: data=%02h perr=%0b ferr=%0b (expected %02h %0b %0b)",
                     frame_no, name, rx_data, rx_perr, rx_ferr, e.data, e.perr, e.ferr);
        end
        frame_no++;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_errors = 1'b1;
        @(negedge clk);
        clear_errors = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int lat;

        //           data   pmode  2sb  flip s1lo s2lo perr ferr
        vecs[0] = '{8'h03, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h03, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h5A, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'h3C, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'hFF, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'h00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{8'h11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{8'hC3, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset rx_valid", rx_valid, 0);
        check("reset fifo_count", fifo_count, 0);
        check("reset rx_data", rx_data, 0);
        check("reset flags", {framing_err, parity_err, overrun, rx_perr, rx_ferr}, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 8N1 0xA5 and latency from the first clock edge that sees the start bit
        cyc = 0;
        fork
            send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            begin
                @(negedge clk);
                while (!rx_valid && cyc < 400) begin
                    @(negedge clk);
                    cyc++;
                end
            end
        join
        push_exp(8'hA5, 1'b0, 1'b0);
        lat = cyc - 1;
        checks++;
        if (lat < 150 || lat > 154) begin
            errors++;
            $display("FAIL latency: got %0d cycles, expected 150..154", lat);
        end
        check("8N1 flags", {framing_err, parity_err, overrun}, 0);
        pop_check("8N1 A5");

        // Table of frame formats
        for (int i = 0; i < 9; i++) begin
            parity_mode = vecs[i].pmode;
            two_stop    = vecs[i].two_sb;
            send_frame(vecs[i].data, vecs[i].pmode, vecs[i].two_sb, vecs[i].par_flip,
                       vecs[i].stop1_low, vecs[i].stop2_low);
            push_exp(vecs[i].data, vecs[i].exp_perr, vecs[i].exp_ferr);
            check($sformatf("vec%0d parity_err", i), parity_err, vecs[i].exp_perr);
            check($sformatf("vec%0d framing_err", i), framing_err, vecs[i].exp_ferr);
            pop_check($sformatf("vec%0d", i));
            pulse_clear();
            check($sformatf("vec%0d cleared", i), {framing_err, parity_err}, 0);
        end

        // Mode inputs change mid-frame: the latched even/one-stop format must still apply
        parity_mode = 2'b01;
        two_stop    = 1'b0;
        fork
            send_frame(8'h96, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
            begin
                repeat (60) @(negedge clk);
                parity_mode = 2'b10;
                two_stop    = 1'b1;
            end
        join
        push_exp(8'h96, 1'b0, 1'b0);
        check("latched mode parity_err", parity_err, 0);
        pop_check("latched mode");
        parity_mode = 2'b00;
        two_stop    = 1'b0;

        // Short low glitch on an idle line
        @(negedge clk);
        rx_in = 1'b0;
        repeat (5) @(negedge clk);
        rx_in = 1'b1;
        repeat (3 * OS) @(negedge clk);
        check("glitch fifo_count", fifo_count, 0);
        check("glitch rx_valid", rx_valid, 0);

        // Five frames into a four-entry FIFO with no reads
        for (int b = 1; b <= 5; b++) begin
            send_frame(8'(b), 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            if (sb_q.size() < DEPTH) push_exp(8'(b), 1'b0, 1'b0);
        end
        check("full fifo_count", fifo_count, DEPTH);
        check("full overrun", overrun, 1);
        pulse_clear();
        check("overrun cleared", overrun, 0);

        // Sixth frame with a pop on its completion cycle
        fork
            send_frame(8'h06, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            begin
                @(negedge clk);
                repeat (154) @(negedge clk);
                check("pop head rx_data", rx_data, sb_q[0].data);
                void'(sb_q.pop_front());
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        join
        push_exp(8'h06, 1'b0, 1'b0);
        check("wr+rd full overrun", overrun, 0);
        check("wr+rd full fifo_count", fifo_count, DEPTH);
        for (int k = 0; k < DEPTH; k++) pop_check($sformatf("drain%0d", k));
        check("drained fifo_count", fifo_count, 0);

        // Reads on an empty FIFO are ignored
        rd_en = 1'b1;
        repeat (3) @(negedge clk);
        rd_en = 1'b0;
        check("empty rd fifo_count", fifo_count, 0);
        send_frame(8'h42, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(8'h42, 1'b0, 1'b0);
        check("after empty rd fifo_count", fifo_count, 1);
        pop_check("after empty rd");

        // Reset during data bit 3, then a clean frame
        @(negedge clk);
        rx_in = 1'b0;
        repeat (OS) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_in = i[0];
            repeat (OS) @(negedge clk);
        end
        rx_in = 1'b0;
        repeat (OS / 2) @(negedge clk);
        rst_n = 1'b0;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12 * OS) @(negedge clk);
        check("mid-frame reset fifo_count", fifo_count, 0);
        check("mid-frame reset rx_valid", rx_valid, 0);
        send_frame(8'h3C, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(8'h3C, 1'b0, 1'b0);
        pop_check("after reset 3C");
        check("final fifo_count", fifo_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_flex.md
UART_RX_FLEX -- requirements
Module: uart_rx_flex

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter OVERSAMPLE, default 16, clk cycles per bit; even, legal range 8..64.
REQ-003 Parameter FIFO_DEPTH, default 4, receive FIFO entries; power of two, legal range 2..64.
REQ-004 clk  input  1  single clock; all logic is on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 rx_in  input  1  raw asynchronous serial line; idles high.
REQ-007 parity_mode  input  2  00 = none, 01 = even, 10 = odd, 11 = treated as none.
REQ-008 two_stop  input  1  1 = two stop bits are checked.
REQ-009 rd_en  input  1  host pops the FIFO head.
REQ-010 clear_errors  input  1  clears the sticky framing_err, parity_err and overrun flags.
REQ-011 rx_data  output  DATA_BITS  FIFO head data, LSB received first.
REQ-012 rx_valid  output  1  FIFO not empty.
REQ-013 rx_perr  output  1  parity error flag stored with the head entry.
REQ-014 rx_ferr  output  1  framing error flag stored with the head entry.
REQ-015 framing_err, parity_err, overrun  output  1 each  sticky error flags.
REQ-016 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.

Function
REQ-017 rx_in SHALL pass through a 2-flop synchronizer before use; the synchronized line SHALL be the only line sampled.
REQ-018 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP1 and STOP2.
REQ-019 In IDLE, a low synchronized line SHALL clear the tick counter and move the FSM to START.
REQ-020 In every non-IDLE state, the sample point SHALL be tick == OVERSAMPLE/2-1, counted from the entry edge, with one bit period every OVERSAMPLE ticks after that.
REQ-021 In START, a high sample SHALL return the FSM to IDLE (glitch rejection) and a low sample SHALL move it to DATA.
REQ-022 On the low START sample, parity_mode and two_stop SHALL be latched; changes to them mid-frame SHALL have no effect.
REQ-023 DATA SHALL shift in DATA_BITS samples, LSB first, using a bit counter.
REQ-024 After the last data bit, the FSM SHALL go to PARITY if parity is enabled, else to STOP1.
REQ-025 The parity check SHALL compute the XOR of the data bits and the parity bit; a result of 1 is an error in even mode and a result of 0 is an error in odd mode.
REQ-026 In STOP1 and STOP2, a low sample SHALL mark a framing error; STOP2 SHALL be entered only when two_stop was latched.
REQ-027 Frame completion SHALL occur on the sample cycle of the last stop bit, and the FSM SHALL return to IDLE on the next cycle, half a bit early, to allow resync.
REQ-028 On completion, a single write of {perr, ferr, data} to the FIFO SHALL occur.
REQ-029 On that write, the sticky flags SHALL set from the frame's perr and ferr.
REQ-030 If perr or ferr set on the same cycle as clear_errors, the set SHALL take priority.
REQ-031 A frame with an error SHALL still be stored in the FIFO.
REQ-032 A write when the FIFO is full and rd_en is low SHALL be dropped and SHALL set overrun.
REQ-033 A write and an rd_en in the same cycle while the FIFO is full SHALL both take effect, and overrun SHALL NOT set.
REQ-034 The FIFO SHALL be show-ahead: rx_data, rx_perr and rx_ferr SHALL be valid whenever rx_valid is high.
REQ-035 rx_valid SHALL rise the cycle after the write into an empty FIFO.
REQ-036 rd_en while the FIFO is empty SHALL be ignored, and the pointers SHALL NOT move.
REQ-037 The FIFO pointers SHALL wrap modulo FIFO_DEPTH, and fifo_count SHALL never exceed FIFO_DEPTH.

Reset
REQ-038 On rst_n low, the FSM SHALL go to IDLE and all counters and pointers SHALL clear to 0.
REQ-039 On rst_n low, the synchronizer flops SHALL reset to 1.
REQ-040 On rst_n low, all outputs SHALL be 0, including rx_valid, fifo_count and every error flag.
REQ-041 Reset asserted mid-frame SHALL discard the partial frame, and no FIFO write SHALL occur.

Structure
REQ-042 The shared package flex_uart_pkg SHALL hold parity_mode_e (PAR_NONE, PAR_EVEN, PAR_ODD) and rx_state_e.
REQ-043 The FIFO SHALL be the sub-module rx_fifo, parameterised by WIDTH and DEPTH, with async reset and show-ahead read.
REQ-044 The synchronizer SHALL reuse the existing bit_synchronizer with RESET_VAL all-ones.

Verification
REQ-045 Defaults, 8N1, byte 0xA5 sent -> rx_data = 0xA5 and rx_valid high 152 +/- 2 cycles after the start edge; no flags set.
REQ-046 Even parity, 0x03 sent with parity bit 1 -> entry stored, rx_perr = 1, parity_err sticky = 1; clear_errors pulse clears parity_err.
REQ-047 A 5-cycle low glitch on an idle line -> FSM returns to IDLE, no FIFO write, fifo_count stays 0.
REQ-048 two_stop = 1, second stop bit driven low, byte 0x5A -> rx_ferr = 1, framing_err = 1, rx_data = 0x5A.
REQ-049 FIFO_DEPTH = 4, five frames 0x01..0x05 with no reads -> fifo_count = 4, overrun = 1, entries 0x01..0x04 read out in order.
REQ-050 FIFO full with rd_en asserted on the completion cycle of a sixth frame -> no overrun, fifo_count stays 4.
REQ-051 rst_n pulsed during data bit 3 -> no write; the next clean frame 0x3C is received correctly.
